// File: rtl/serial_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_sub_pkg : shared FSM state encoding and default operand width  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int C_DEFAULT_W = 4;

endpackage
`default_nettype wire

// File: rtl/half_sub_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_sub_cell : combinational one-bit half subtractor (a - b)         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_sub_ctrl : bit-serial W-bit subtractor, LSB first, busy/done   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W  = C_DEFAULT_W,
  parameter int CW = $clog2(W)
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a_s;
  logic [W-1:0]  r_b_s;
  logic [W-2:0]  r_acc;
  logic          r_br;
  logic [CW-1:0] r_cnt;

  logic          w_d1;
  logic          w_b1;
  logic          w_d;
  logic          w_b2;
  logic          w_br_next;
  logic          w_last;
  logic [W-1:0]  w_acc_next;

  half_sub_cell u_hs0 (
    .a  (r_a_s[0]),
    .b  (r_b_s[0]),
    .d  (w_d1),
    .bo (w_b1)
  );

  half_sub_cell u_hs1 (
    .a  (w_d1),
    .b  (r_br),
    .d  (w_d),
    .bo (w_b2)
  );

  assign w_br_next  = w_b1 | w_b2;
  assign w_last     = (r_cnt == CW'(W-1));
  // New bit enters at the MSB; after W shifts this is the full difference.
  assign w_acc_next = {w_d, r_acc};

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_a_s <= '0;
      r_b_s <= '0;
      r_acc <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_s <= a;
            r_b_s <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a_s <= r_a_s >> 1;
          r_b_s <= r_b_s >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          r_acc <= w_acc_next[W-1:1];
          // Outputs only change once the whole word is ready.
          if (w_last) begin
            diff <= w_acc_next;
            bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_sub_ctrl : scoreboard bench with random and directed ops    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_sub_ctrl;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  serial_sub_ctrl #(.W(W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d;
    int bo;
  } res_t;

  res_t sb[$];
  res_t pend;
  int   cnt         = 0;
  int   held_d      = 0;
  int   held_b      = 0;
  int   n_done_exp  = 0;
  int   n_done_seen = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request occupies the unit for W+1 cycles;
  // its result is a - b mod 2^W with a borrow when a < b.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt    = 0;
      held_d = 0;
      held_b = 0;
      sb.delete();
    end else if (cnt == 0) begin
      if (start) begin
        pend.d  = (int'(a) + M - int'(b)) % M;
        pend.bo = (a < b) ? 1 : 0;
        sb.push_back(pend);
        cnt = W + 1;
      end
    end else begin
      if (cnt == 2) begin
        held_d = pend.d;
        held_b = pend.bo;
        n_done_exp++;
      end
      cnt--;
    end
  end

  // Monitor: handshake timing, held outputs and scoreboard pops on done.
  always @(negedge clock) begin
    res_t r;
    chk("busy", int'(busy), int'(cnt > 0));
    chk("done", int'(done), int'(cnt == 1));
    chk("diff_held", int'(diff), held_d);
    chk("bout_held", int'(bout), held_b);
    if (done) begin
      n_done_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: done=1 with no outstanding op, expected done=0 (t=%0t)", $time);
      end else begin
        r = sb.pop_front();
        chk("sb_diff", int'(diff), r.d);
        chk("sb_bout", int'(bout), r.bo);
      end
    end
  end

  task automatic op(input int ai, input int bi);
    @(negedge clock);
    start = 1'b1;
    a     = W'(ai);
    b     = W'(bi);
    @(negedge clock);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    repeat (W + 2) @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b1;
    @(negedge clock);

    op(5, 3);
    op(3, 5);
    op(0, 1);
    op(15, 15);
    op(0, 0);

    // Start pulse two cycles into SHIFT must be ignored.
    @(negedge clock);
    start = 1'b1; a = 4'd5; b = 4'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1; a = 4'd12; b = 4'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (W + 2) @(negedge clock);

    // Asynchronous reset while bit 2 is pending.
    @(negedge clock);
    start = 1'b1; a = 4'd6; b = 4'd2;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    @(negedge clock);
    @(negedge clock);
    #2 rst_n = 1'b1;
    op(9, 4);

    // Start held high: one operation every W+2 cycles.
    @(negedge clock);
    start = 1'b1; a = 4'd8; b = 4'd1;
    repeat (3 * (W + 2)) @(negedge clock);
    start = 1'b0;
    repeat (W + 3) @(negedge clock);

    // Random traffic, including starts while busy and changing operands.
    repeat (300) begin
      @(negedge clock);
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(negedge clock);
    start = 1'b0;
    repeat (W + 3) @(negedge clock);

    chk("sb_drained", sb.size(), 0);
    chk("done_count", n_done_seen, n_done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial N-bit subtractor controller built around the half-subtractor datapath cell.
- Latches two W-bit operands on a start request.
- Sequences them LSB-first through a two-half-subtractor borrow chain with a registered borrow, one bit per clock.
- Returns the W-bit difference and the final borrow with a busy/done handshake.
- Sits between a requesting controller and the half-subtractor cells; lets one small subtract cell serve wide operands.

Parameters:
- W, 4, operand/result width in bits; legal range W >= 2.
- CW, $clog2(W), bit-counter width; derived, not overridden.

Ports:
- clock  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a      input  W  minuend; sampled with start.
- b      input  W  subtrahend; sampled with start.
- busy   output 1  high whenever state != IDLE.
- done   output 1  one-cycle pulse; result valid.
- diff   output W  registered difference, a - b mod 2^W.
- bout   output 1  registered final borrow; 1 iff a < b unsigned.

Behaviour:
Reset (rst_n low, async):
- state = IDLE; busy = 0, done = 0, diff = 0, bout = 0.
- Internal operand shift registers, borrow flop and bit counter all cleared.
- Takes effect immediately, including mid-operation; an aborted operation produces no done.

States: IDLE, SHIFT, DONE.
- IDLE: on an edge with start = 1:
  - latch a and b into shift registers; borrow flop = 0; count = 0; go to SHIFT.
  - diff/bout keep their previous values until the new result completes.
- SHIFT: each edge processes bit a_s[0], b_s[0]:
  - hs0: d1 = a^b, b1 = ~a & b.
  - hs1: d = d1 ^ br, b2 = ~d1 & br.
  - br_next = b1 | b2.
  - d shifts into diff result register from the MSB side; operands shift right; count++.
  - When count == W-1 on that edge: capture bout = br_next, go to DONE.
- DONE: done = 1 for exactly this one cycle; next edge returns to IDLE.
- start while in SHIFT or DONE is ignored, not queued. Operand input changes after acceptance have no effect.

Latency:
- start sampled at edge k; result on diff/bout and done = 1 during the cycle after edge k+W.
- busy high from after edge k through the DONE cycle (W+1 cycles).
- Back-to-back throughput: one operation per W+2 cycles.

Output holding:
- diff/bout are stable from DONE until the next operation's final SHIFT edge.
- diff is built in a working register and copied to the output at the W-th edge, so the output never shows partial results.

Arithmetic:
- Unsigned modulo 2^W. Wrap-around is expressed only through bout; no overflow flag.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - default width constant.
- One natural sub-module: half_sub_cell (combinational a, b -> d, bo), instantiated twice for the borrow chain.
- Controller FSM, counter and shift registers live in serial_sub_ctrl.

Test Plan:
- W=4, after reset, start with a=5, b=3 -> done pulse exactly W+1=5 cycles after the start edge; diff=2, bout=0; busy high 5 cycles.
- a=3, b=5 -> diff=4'b1110 (14), bout=1.
- Boundaries: a=0, b=1 -> diff=15, bout=1; a=15, b=15 -> diff=0, bout=0; a=0, b=0 -> diff=0, bout=0.
- Pulse start again 2 cycles into a SHIFT with different operands -> ignored; first result unchanged; only one done pulse.
- Assert rst_n low mid-SHIFT (bit 2) -> all outputs 0 immediately, no done; a new start after release gives the correct result (9-4 -> 5, bout 0).
- start held high continuously with a=8, b=1 -> done every W+2=6 cycles; diff=7 each time.
